// File: rtl/bist_sequencer_pkg.sv
// Shared widths and FSM encoding for the 256x4 SRAM BIST sequencer.
package bist_sequencer_pkg;

  localparam int SRAM_ADDR_WIDTH  = 8;
  localparam int SRAM_DATA_WIDTH  = 4;
  localparam int CH_COUNTER_WIDTH = SRAM_ADDR_WIDTH + 3;
  localparam int FAIL_CNT_WIDTH   = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN1 = 3'd3,
    ST_DRAIN2 = 3'd4,
    ST_DONE   = 3'd5
  } bist_state_t;

endpackage

// File: rtl/bist_sequencer_compare.sv
// Read-data compare stage: delays the expected word by the SRAM read latency,
// flags mismatches, keeps the first failing address/phase and a saturating count.
module bist_sequencer_compare
  import bist_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clear,
  input  logic                      i_rd_valid,
  input  logic [DATA_WIDTH-1:0]     i_exp,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  input  logic                      i_phase,
  input  logic [DATA_WIDTH-1:0]     i_rdata,
  output logic [ADDR_WIDTH-1:0]     o_fail_addr,
  output logic                      o_fail_phase,
  output logic [FAIL_CNT_WIDTH-1:0] o_fail_count
);

  logic                      r_s1_valid;
  logic [DATA_WIDTH-1:0]     r_s1_exp;
  logic [ADDR_WIDTH-1:0]     r_s1_addr;
  logic                      r_s1_phase;
  logic [ADDR_WIDTH-1:0]     r_fail_addr;
  logic                      r_fail_phase;
  logic [FAIL_CNT_WIDTH-1:0] r_fail_count;
  logic                      w_mismatch;

  assign w_mismatch = r_s1_valid && (i_rdata != r_s1_exp);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_exp     <= '0;
      r_s1_addr    <= '0;
      r_s1_phase   <= 1'b0;
      r_fail_addr  <= '0;
      r_fail_phase <= 1'b0;
      r_fail_count <= '0;
    end else begin
      // Stage 1 lines up with the cycle in which the SRAM samples the read.
      r_s1_valid <= i_rd_valid && !i_clear;
      r_s1_exp   <= i_exp;
      r_s1_addr  <= i_addr;
      r_s1_phase <= i_phase;
      if (i_clear) begin
        r_fail_addr  <= '0;
        r_fail_phase <= 1'b0;
        r_fail_count <= '0;
      end else if (w_mismatch) begin
        // A zero count means no earlier mismatch, so this one is the first.
        if (r_fail_count == '0) begin
          r_fail_addr  <= r_s1_addr;
          r_fail_phase <= r_s1_phase;
        end
        if (r_fail_count != '1) begin
          r_fail_count <= r_fail_count + FAIL_CNT_WIDTH'(1);
        end
      end
    end
  end

  assign o_fail_addr  = r_fail_addr;
  assign o_fail_phase = r_fail_phase;
  assign o_fail_count = r_fail_count;

endmodule

// File: rtl/bist_sequencer.sv
// BIST controller for a 256x4 single-port SRAM: drives the checkerboard step
// counter, turns each step into an SRAM command and arbitrates with the functional port.
module bist_sequencer
  import bist_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int CNT_WIDTH  = CH_COUNTER_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      func_req,
  input  logic                      func_we,
  input  logic [ADDR_WIDTH-1:0]     func_addr,
  input  logic [DATA_WIDTH-1:0]     func_wdata,
  output logic                      func_gnt,
  output logic [DATA_WIDTH-1:0]     func_rdata,
  output logic                      ch_rst,
  output logic                      ch_cen,
  input  logic [CNT_WIDTH-2:0]      ch_out,
  input  logic                      ch_cout,
  output logic                      sram_ce,
  output logic                      sram_we,
  output logic [ADDR_WIDTH-1:0]     sram_addr,
  output logic [DATA_WIDTH-1:0]     sram_wdata,
  input  logic [DATA_WIDTH-1:0]     sram_rdata,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [ADDR_WIDTH-1:0]     fail_addr,
  output logic                      fail_phase,
  output logic [FAIL_CNT_WIDTH-1:0] fail_count
);

  localparam int PAT_BIT = ADDR_WIDTH + 1;
  localparam int WR_BIT  = ADDR_WIDTH;

  bist_state_t           r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic                  r_ch_rst;
  logic                  r_sram_ce;
  logic                  r_sram_we;
  logic [ADDR_WIDTH-1:0] r_sram_addr;
  logic [DATA_WIDTH-1:0] r_sram_wdata;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_exp;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_rd_phase;
  logic                  w_func_own;
  logic                  w_start_ok;
  logic [DATA_WIDTH-1:0] w_pat_word;

  assign w_func_own = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_start_ok = w_func_own && start;
  assign w_pat_word = {DATA_WIDTH{ch_out[PAT_BIT]}};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_ch_rst     <= 1'b1;
      r_sram_ce    <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_exp     <= '0;
      r_rd_addr    <= '0;
      r_rd_phase   <= 1'b0;
    end else begin
      r_sram_ce  <= 1'b0;
      r_sram_we  <= 1'b0;
      r_rd_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state  <= ST_CLR;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_ch_rst <= 1'b1;
          end
        end
        ST_CLR: begin
          r_state  <= ST_RUN;
          r_ch_rst <= 1'b0;
        end
        ST_RUN: begin
          // Carry means the counter is about to wrap; the last step was already issued.
          if (!ch_cout) begin
            r_sram_ce    <= 1'b1;
            r_sram_we    <= ch_out[WR_BIT];
            r_sram_addr  <= ch_out[ADDR_WIDTH-1:0];
            r_sram_wdata <= w_pat_word;
            r_rd_valid   <= !ch_out[WR_BIT];
            r_rd_exp     <= w_pat_word;
            r_rd_addr    <= ch_out[ADDR_WIDTH-1:0];
            r_rd_phase   <= ch_out[PAT_BIT];
          end else begin
            r_state  <= ST_DRAIN1;
            r_ch_rst <= 1'b1;
          end
        end
        ST_DRAIN1: r_state <= ST_DRAIN2;
        ST_DRAIN2: begin
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= (fail_count == '0);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  bist_sequencer_compare #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_compare (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_start_ok),
    .i_rd_valid   (r_rd_valid),
    .i_exp        (r_rd_exp),
    .i_addr       (r_rd_addr),
    .i_phase      (r_rd_phase),
    .i_rdata      (sram_rdata),
    .o_fail_addr  (fail_addr),
    .o_fail_phase (fail_phase),
    .o_fail_count (fail_count)
  );

  // The functional port reaches the SRAM combinationally only while BIST is parked.
  assign func_gnt   = w_func_own && func_req;
  assign func_rdata = sram_rdata;
  assign sram_ce    = w_func_own ? func_req            : r_sram_ce;
  assign sram_we    = w_func_own ? (func_req && func_we) : r_sram_we;
  assign sram_addr  = w_func_own ? func_addr           : r_sram_addr;
  assign sram_wdata = w_func_own ? func_wdata          : r_sram_wdata;

  assign ch_rst = r_ch_rst;
  assign ch_cen = (r_state == ST_RUN) && !ch_cout;
  assign busy   = r_busy;
  assign done   = r_done;
  assign pass   = r_pass;

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench: models the checkerboard counter and a 256x4 SRAM with
// selectable read faults, then checks status, latency and arbitration.
module tb_bist_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       func_req;
  logic       func_we;
  logic [7:0] func_addr;
  logic [3:0] func_wdata;
  logic       func_gnt;
  logic [3:0] func_rdata;
  logic       ch_rst;
  logic       ch_cen;
  logic [9:0] ch_out;
  logic       ch_cout;
  logic       sram_ce;
  logic       sram_we;
  logic [7:0] sram_addr;
  logic [3:0] sram_wdata;
  logic [3:0] sram_rdata;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] fail_addr;
  logic       fail_phase;
  logic [7:0] fail_count;

  int n_compared = 0;
  int n_mismatch = 0;
  int fault_mode = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int bad_busy;
  int bad_gnt;
  int lat;
  int wr0;
  int rd0;

  logic [10:0] cnt;
  logic [3:0]  mem [256];

  always #5 clk = ~clk;

  bist_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .func_req   (func_req),
    .func_we    (func_we),
    .func_addr  (func_addr),
    .func_wdata (func_wdata),
    .func_gnt   (func_gnt),
    .func_rdata (func_rdata),
    .ch_rst     (ch_rst),
    .ch_cen     (ch_cen),
    .ch_out     (ch_out),
    .ch_cout    (ch_cout),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_addr  (fail_addr),
    .fail_phase (fail_phase),
    .fail_count (fail_count)
  );

  // Step counter: writes come first in each 512-step half, so bit 8 is inverted.
  always @(posedge clk) begin
    if (ch_rst) cnt <= '0;
    else if (ch_cen) cnt <= cnt + 11'd1;
  end
  assign ch_out  = {cnt[9], ~cnt[8], cnt[7:0]};
  assign ch_cout = cnt[10];

  function automatic logic [3:0] fault_read(input logic [3:0] d, input logic [7:0] a);
    if (fault_mode == 1 && a == 8'h05) return d & 4'b1011;
    if (fault_mode == 2) return 4'hF;
    return d;
  endfunction

  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else sram_rdata <= fault_read(mem[sram_addr], sram_addr);
      if (busy) begin
        if (sram_we) wr_cnt <= wr_cnt + 1;
        else rd_cnt <= rd_cnt + 1;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Pulses start, optionally re-pulses it mid-run, and measures edges until done.
  task automatic run_bist(input int repulse_at);
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    bad_busy = 0;
    bad_gnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("start_done_cleared", 32'(done), 32'd0);
    lat = 0;
    while (done !== 1'b1 && lat < 1200) begin
      if (busy !== 1'b1) bad_busy++;
      if (func_gnt !== 1'b0) bad_gnt++;
      start = (repulse_at > 0 && lat == repulse_at);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    func_req = 1'b0;
    func_we = 1'b0;
    func_addr = '0;
    func_wdata = '0;
    sram_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);

    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_pass", 32'(pass), 32'd0);
    check_val("rst_fail_addr", 32'(fail_addr), 32'd0);
    check_val("rst_fail_phase", 32'(fail_phase), 32'd0);
    check_val("rst_fail_count", 32'(fail_count), 32'd0);
    check_val("rst_sram_ce", 32'(sram_ce), 32'd0);
    check_val("rst_sram_we", 32'(sram_we), 32'd0);
    check_val("rst_sram_addr", 32'(sram_addr), 32'd0);
    check_val("rst_sram_wdata", 32'(sram_wdata), 32'd0);
    check_val("rst_ch_rst", 32'(ch_rst), 32'd1);
    check_val("rst_ch_cen", 32'(ch_cen), 32'd0);
    check_val("rst_func_gnt", 32'(func_gnt), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Fault-free run
    fault_mode = 0;
    run_bist(0);
    check_val("clean_latency", 32'(lat), 32'd1028);
    check_val("clean_busy_held", 32'(bad_busy), 32'd0);
    check_val("clean_busy_low", 32'(busy), 32'd0);
    check_val("clean_pass", 32'(pass), 32'd1);
    check_val("clean_fail_count", 32'(fail_count), 32'd0);
    check_val("clean_writes", 32'(wr_cnt - wr0), 32'd512);
    check_val("clean_reads", 32'(rd_cnt - rd0), 32'd512);
    repeat (5) @(negedge clk);
    check_val("clean_done_sticky", 32'(done), 32'd1);

    // Bit 2 of address 0x05 stuck at 0
    fault_mode = 1;
    run_bist(0);
    check_val("stuck_latency", 32'(lat), 32'd1028);
    check_val("stuck_pass", 32'(pass), 32'd0);
    check_val("stuck_fail_addr", 32'(fail_addr), 32'h05);
    check_val("stuck_fail_phase", 32'(fail_phase), 32'd1);
    check_val("stuck_fail_count", 32'(fail_count), 32'd1);

    // Every word reads 4'hF
    fault_mode = 2;
    run_bist(0);
    check_val("allf_latency", 32'(lat), 32'd1028);
    check_val("allf_pass", 32'(pass), 32'd0);
    check_val("allf_fail_count", 32'(fail_count), 32'd255);
    check_val("allf_fail_addr", 32'(fail_addr), 32'h00);
    check_val("allf_fail_phase", 32'(fail_phase), 32'd0);

    // Functional requests held through a run
    fault_mode = 0;
    func_req = 1'b1;
    func_we = 1'b0;
    @(negedge clk);
    check_val("arb_gnt_done_before", 32'(func_gnt), 32'd1);
    run_bist(0);
    check_val("arb_gnt_blocked", 32'(bad_gnt), 32'd0);
    check_val("arb_gnt_done_after", 32'(func_gnt), 32'd1);
    check_val("arb_pass", 32'(pass), 32'd1);
    func_we = 1'b1;
    func_addr = 8'h33;
    func_wdata = 4'hA;
    @(negedge clk);
    func_we = 1'b0;
    @(negedge clk);
    check_val("arb_func_rdata", 32'(func_rdata), 32'hA);
    func_req = 1'b0;
    func_addr = '0;
    func_wdata = '0;
    @(negedge clk);
    check_val("arb_gnt_released", 32'(func_gnt), 32'd0);

    // Reset in the middle of a run, then restart
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (602) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_done", 32'(done), 32'd0);
    check_val("midrst_ch_rst", 32'(ch_rst), 32'd1);
    check_val("midrst_sram_ce", 32'(sram_ce), 32'd0);
    check_val("midrst_fail_count", 32'(fail_count), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    run_bist(0);
    check_val("restart_latency", 32'(lat), 32'd1028);
    check_val("restart_pass", 32'(pass), 32'd1);

    // Start re-pulsed while running
    run_bist(300);
    check_val("repulse_latency", 32'(lat), 32'd1028);
    check_val("repulse_pass", 32'(pass), 32'd1);
    check_val("repulse_writes", 32'(wr_cnt - wr0), 32'd512);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/bist_sequencer.md
Name: bist_sequencer

Overview:
- Top-level BIST controller for the 256x4 single-port SRAM.
- Sequences the checkerboard step counter through its clear/enable/carry handshake and turns each counter output into an SRAM write or read.
- Pipelines read data into a compare stage and records pass/fail status, the first failing address and a fail count.
- Arbitrates the SRAM between the functional port and BIST: the functional side owns the SRAM only when BIST is idle or done.

Parameters:
- ADDR_WIDTH, 8, SRAM address width.
- DATA_WIDTH, 4, SRAM word width.
- CNT_WIDTH, ADDR_WIDTH+3 (11), checkerboard counter width including the carry bit.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle request to begin BIST.
- func_req  in  1  functional access request.
- func_we  in  1  functional write enable.
- func_addr  in  ADDR_WIDTH  functional address.
- func_wdata  in  DATA_WIDTH  functional write data.
- func_gnt  out  1  functional access accepted this cycle.
- func_rdata  out  DATA_WIDTH  SRAM read data, passthrough.
- ch_rst  out  1  checkerboard counter clear.
- ch_cen  out  1  checkerboard counter enable.
- ch_out  in  ADDR_WIDTH+2  counter output: bit 9 = pattern bit, bit 8 = write phase, bits 7:0 = address.
- ch_cout  in  1  counter carry; 1 once all 1024 steps are done.
- sram_ce  out  1  SRAM chip enable.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  ADDR_WIDTH  SRAM address.
- sram_wdata  out  DATA_WIDTH  SRAM write data.
- sram_rdata  in  DATA_WIDTH  SRAM read data, valid one cycle after the read command.
- busy  out  1  BIST in progress.
- done  out  1  BIST complete; sticky until next start or reset.
- pass  out  1  valid while done; 1 means no mismatch.
- fail_addr  out  ADDR_WIDTH  address of the first mismatch.
- fail_phase  out  1  pattern bit (ch_out[9]) of the first mismatch.
- fail_count  out  8  mismatch count, saturating at 255.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State returns to IDLE.
  - Outputs: busy=0, done=0, pass=0, fail_addr=0, fail_phase=0, fail_count=0, sram_ce=0, sram_we=0, sram_addr=0, sram_wdata=0, ch_rst=1, ch_cen=0, func_gnt=0.
  - Reset mid-run aborts the run with no partial status kept.
- States: IDLE, CLR, RUN, DRAIN1, DRAIN2, DONE.
- IDLE / DONE:
  - func_gnt = func_req; the functional command goes to the SRAM combinationally.
  - start=1 moves to CLR and clears done, pass, fail_*.
  - start while in CLR, RUN or DRAIN is ignored.
- CLR (1 cycle):
  - ch_rst=1, ch_cen=0, busy=1, func_gnt=0.
  - Next state RUN; counter is 0 on entry to RUN.
- RUN:
  - ch_cen = !ch_cout.
  - While ch_cout=0, register one SRAM command per cycle from ch_out:
    - sram_ce=1, sram_we=ch_out[8], sram_addr=ch_out[7:0].
    - sram_wdata = {DATA_WIDTH{ch_out[9]}}.
  - ch_cout=1: issue no command (the counter would wrap to address 0); next state DRAIN1.
  - Step order: write pattern (256), read pattern (256), write inverted pattern (256), read inverted pattern (256).
- Compare pipeline:
  - For each read command, register the expected word and address alongside it.
  - Compare sram_rdata against the expected word the cycle after the SRAM samples the read.
  - On mismatch: fail_count+1, saturating at 255.
  - Capture fail_addr/fail_phase on the first mismatch only.
- DRAIN1, DRAIN2:
  - sram_ce=0; the compare pipeline empties.
  - Then DONE: busy=0, done=1, pass=(fail_count==0).
- Latency: if start is sampled at edge k, done rises at edge k+1028.
- func_rdata is driven from sram_rdata at all times; it is meaningful only for a granted read, one cycle later.

Decomposition:
- Shared parameters include (existing): SRAM_ADDR_WIDTH, SRAM_DATA_WIDTH, CH_COUNTER_WIDTH.
- Add to it: BIST state encodings and FAIL_CNT_WIDTH=8.
- One sub-module: bist_compare (expected/address pipeline, mismatch detect, first-fail capture, saturating count).

Test Plan:
- Fault-free SRAM model, start pulse → busy=1 for the run; done at start+1028; pass=1, fail_count=0; exactly 512 writes and 512 reads issued.
- Bit 2 of address 0x05 stuck-at-0 → pass=0, fail_addr=0x05, fail_phase=1, fail_count=1 (read 4'b1011, expected 4'b1111).
- Every word reads 4'hF → fail_count=255 (saturated), fail_addr=0x00, fail_phase=0.
- func_req=1 throughout a run → func_gnt=0 during CLR..DRAIN2, func_gnt=1 in IDLE and DONE; a functional write then read of addr 0x33 returns the written data.
- rst=0 at RUN step 600, then start → run restarts cleanly: done at start+1028, pass=1.
- start re-pulsed in RUN → ignored; total latency unchanged.
